// File: rtl/cl2st_before_afu.sv
// ============================================================================
//  Module      : cl2st_before_afu
//  Description : Cache-line to ST-stream converter in front of the AFU.
//                Pops one cache line from a show-ahead-less FIFO (data one
//                cycle after rdreq), decodes its head (sop, eop, length) and
//                emits `length` ST beats of ST2 bits each with valid/ready
//                handshaking. Lengths above MaxNumOfST_inCL are clamped and
//                zero-length lines are dropped.
//  Options     : CL2ST_LEN_CHECK_EN - when defined, len_err latches on any
//                zero or over-long length field (sticky until reset);
//                otherwise len_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cl2st_before_afu #(
   parameter int CL              = 512,
   parameter int CL_HEAD         = 16,
   parameter int CL_PAYLOAD      = 496,
   parameter int ST2             = 8,
   parameter int MaxNumOfST_inCL = 41,
   parameter int w_len_CLHead    = 10
) (
   input  logic            clk,
   input  logic            rst_async,
   input  logic            ff_empty,
   output logic            ff_rdreq,
   input  logic [CL-1:0]   ff_q,
   input  logic            source_ready,
   output logic            source_valid,
   output logic [ST2-1:0]  source_data,
   output logic            source_sop,
   output logic            source_eop,
   output logic            len_err
);

   // Width able to hold a clamped length (0..MaxNumOfST_inCL); idx shares it.
   localparam int LEN_W = $clog2(MaxNumOfST_inCL + 1);

   localparam logic [w_len_CLHead-1:0] MAX_LEN = w_len_CLHead'(MaxNumOfST_inCL);
   localparam logic [LEN_W-1:0]        MAX_LEN_CLAMP = LEN_W'(MaxNumOfST_inCL);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] EMIT  = 2'd3;

   logic [1:0]              state;
   logic [CL_PAYLOAD-1:0]   line_q;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        idx;
   logic                    sop_flag;
   logic                    eop_flag;

   logic [w_len_CLHead-1:0] raw_len;
   logic                    head_sop;
   logic                    head_eop;
   logic                    len_zero;
   logic                    len_over;
   logic [LEN_W-1:0]        clamped_len;
   logic                    emit;
   logic                    last_beat;
   logic                    unused_ff_q;

   // Head decode straight off the FIFO word; only meaningful during LOAD.
   assign raw_len     = ff_q[CL-CL_HEAD +: w_len_CLHead];
   assign head_sop    = ff_q[CL-5];
   assign head_eop    = ff_q[CL-6];
   assign len_zero    = (raw_len == '0);
   assign len_over    = (raw_len > MAX_LEN);
   assign clamped_len = len_over ? MAX_LEN_CLAMP : LEN_W'(raw_len);

   // Reserved head bits carry no meaning for this block.
   assign unused_ff_q = ^ff_q;

   assign emit      = (state == EMIT);
   assign last_beat = (idx == len_q - LEN_W'(1));

   // All outputs decode registered state only: no path from ready/empty.
   assign ff_rdreq     = (state == FETCH);
   assign source_valid = emit;
   assign source_data  = line_q[int'(idx)*ST2 +: ST2];
   assign source_sop   = emit && sop_flag && (idx == '0);
   assign source_eop   = emit && eop_flag && last_beat;

   // Line fetch / beat emission state machine with its datapath registers.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state    <= IDLE;
         line_q   <= '0;
         len_q    <= '0;
         idx      <= '0;
         sop_flag <= 1'b0;
         eop_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!ff_empty) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               line_q   <= ff_q[CL_PAYLOAD-1:0];
               len_q    <= clamped_len;
               sop_flag <= head_sop;
               eop_flag <= head_eop;
               idx      <= '0;
               // A zero-length line is consumed but produces no beats.
               state    <= len_zero ? IDLE : EMIT;
            end
            EMIT: begin
               if (source_ready) begin
                  if (last_beat) begin
                     idx   <= '0;
                     state <= IDLE;
                  end else begin
                     idx <= idx + LEN_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CL2ST_LEN_CHECK_EN
   logic len_err_q;

   // Sticky flag for a malformed length field seen at line load.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         len_err_q <= 1'b0;
      end else if ((state == LOAD) && (len_zero || len_over)) begin
         len_err_q <= 1'b1;
      end
   end

   assign len_err = len_err_q;
`else
   assign len_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cl2st_before_afu.sv
// ============================================================================
//  Module      : tb_cl2st_before_afu
//  Description : Self-checking bench for cl2st_before_afu. A FIFO model feeds
//                cache lines; a queue-based reference derives the expected
//                beat stream from the line contents, and a monitor checks
//                beats, stall stability, latency and gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cl2st_before_afu;

   localparam int MAXST = 41;
`ifdef CL2ST_LEN_CHECK_EN
   localparam bit LEN_CHK = 1'b1;
`else
   localparam bit LEN_CHK = 1'b0;
`endif

   logic          clk;
   logic          rst_async;
   logic          ff_empty;
   logic          ff_rdreq;
   logic [511:0]  ff_q;
   logic          source_ready;
   logic          source_valid;
   logic [7:0]    source_data;
   logic          source_sop;
   logic          source_eop;
   logic          len_err;

   cl2st_before_afu #(
      .CL(512), .CL_HEAD(16), .CL_PAYLOAD(496), .ST2(8),
      .MaxNumOfST_inCL(41), .w_len_CLHead(10)
   ) dut (
      .clk(clk), .rst_async(rst_async), .ff_empty(ff_empty), .ff_rdreq(ff_rdreq),
      .ff_q(ff_q), .source_ready(source_ready), .source_valid(source_valid),
      .source_data(source_data), .source_sop(source_sop), .source_eop(source_eop),
      .len_err(len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters and checker ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- FIFO model ----------------
   logic [511:0] mem [0:127];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign ff_empty = (wr_ptr == rd_ptr);

   initial begin
      ff_q = '0;
      forever begin
         @(posedge clk);
         if (ff_rdreq && (rd_ptr != wr_ptr)) begin
            ff_q   <= mem[rd_ptr % 128];
            rd_ptr <= rd_ptr + 1;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [9:0] exp_q [$];      // {sop, eop, data}
   int  exp_pushed  = 0;
   bit  exp_len_err = 1'b0;

   function automatic logic [495:0] rand_payload();
      logic [511:0] t;
      for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
      return t[495:0];
   endfunction

   task automatic push_line(input logic [9:0] len, input logic sop, input logic eop,
                            input logic [495:0] payload);
      int n;
      n = (len > 10'(MAXST)) ? MAXST : int'(len);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({sop && (k == 0), eop && (k == n - 1), payload[k*8 +: 8]});
         exp_pushed++;
      end
      if (LEN_CHK && (len == 10'd0 || len > 10'(MAXST))) exp_len_err = 1'b1;
      mem[wr_ptr % 128] = {4'($urandom), sop, eop, len, payload};
      wr_ptr = wr_ptr + 1;
   endtask

   // ---------------- ready driver ----------------
   int ready_mode = 0;   // 0: always 1, 1: alternate, 2: random
   initial begin
      source_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       source_ready = 1'b1;
            1:       source_ready = ~source_ready;
            default: source_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- monitor ----------------
   int         acc_cnt    = 0;
   int         rd_pulses  = 0;
   int         stall_cnt  = 0;
   int         rd_age     = 99;
   int         gap        = 0;
   int         last_gap   = 0;
   bit         prev_valid = 1'b0;
   bit         prev_stall = 1'b0;
   logic [9:0] prev_beat  = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_async) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            rd_age     = 99;
            gap        = 0;
         end else begin
            if (ff_rdreq) begin
               rd_age = 0;
               rd_pulses++;
            end else if (rd_age < 99) begin
               rd_age++;
            end
            if (prev_stall) begin
               stall_cnt++;
               check_eq("stall_valid", 32'(source_valid), 32'd1);
               check_eq("stall_hold", 32'({source_sop, source_eop, source_data}), 32'(prev_beat));
            end
            if (source_valid && !prev_valid) begin
               check_eq("first_beat_latency", 32'(rd_age), 32'd2);
               last_gap = gap;
            end
            if (!source_valid) begin
               check_eq("idle_flags", 32'({source_sop, source_eop}), 32'd0);
               gap++;
            end else if (source_ready) begin
               acc_cnt++;
               gap = 0;
               if (exp_q.size() == 0) begin
                  check_eq("extra_beat", 32'({source_sop, source_eop, source_data}), 32'h3ff);
               end else begin
                  check_eq("beat", 32'({source_sop, source_eop, source_data}), 32'(exp_q.pop_front()));
               end
            end
            prev_valid = source_valid;
            prev_stall = source_valid && !source_ready;
            prev_beat  = {source_sop, source_eop, source_data};
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || wr_ptr != rd_ptr || source_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_timeout", 32'(n >= 5000), 32'd0);
      repeat (6) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [495:0] p;
      int           base_acc;
      int           base_rd;
      int           n;
      int           r;
      logic [9:0]   len;

      rst_async = 1'b1;
      #1;
      check_eq("reset_outputs",
               32'({ff_rdreq, source_valid, source_data, source_sop, source_eop, len_err}), 32'd0);
      repeat (3) @(negedge clk);
      rst_async = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("idle_no_rdreq", 32'(rd_pulses), 32'd0);

      // Test 1: one full line, bytes 0..40, ready held high
      ready_mode = 0;
      base_acc = acc_cnt; base_rd = rd_pulses;
      p = rand_payload();
      for (int k = 0; k < MAXST; k++) p[k*8 +: 8] = 8'(k);
      push_line(10'd41, 1'b1, 1'b1, p);
      wait_drain();
      check_eq("t1_beats", 32'(acc_cnt - base_acc), 32'd41);
      check_eq("t1_rdreq_pulses", 32'(rd_pulses - base_rd), 32'd1);

      // Test 2: back-to-back lines, B has garbage above ST 4
      base_acc = acc_cnt;
      push_line(10'd41, 1'b1, 1'b0, rand_payload());
      push_line(10'd5, 1'b0, 1'b1, rand_payload() | {{491{1'b1}}, 40'h0});
      wait_drain();
      check_eq("t2_beats", 32'(acc_cnt - base_acc), 32'd46);
      check_eq("t2_gap", 32'(last_gap), 32'd3);

      // Test 3: alternating ready on a 10-beat line
      ready_mode = 1;
      base_acc = acc_cnt; n = stall_cnt;
      push_line(10'd10, 1'b1, 1'b1, rand_payload());
      wait_drain();
      check_eq("t3_beats", 32'(acc_cnt - base_acc), 32'd10);
      check_eq("t3_stalls_seen", 32'(stall_cnt > n), 32'd1);
      ready_mode = 0;

      // Test 4: zero-length line dropped, then a 3-beat line
      base_acc = acc_cnt;
      push_line(10'd0, 1'b1, 1'b1, rand_payload());
      push_line(10'd3, 1'b1, 1'b1, rand_payload());
      wait_drain();
      check_eq("t4_beats", 32'(acc_cnt - base_acc), 32'd3);
      check_eq("t4_len_err", 32'(len_err), 32'(exp_len_err));

      // Test 5: over-long length clamped
      base_acc = acc_cnt;
      push_line(10'd50, 1'b0, 1'b1, rand_payload());
      wait_drain();
      check_eq("t5_beats", 32'(acc_cnt - base_acc), 32'd41);
      check_eq("t5_len_err", 32'(len_err), 32'(exp_len_err));

      // Test 6: reset after beat 10 of 41, then a fresh line
      base_acc = acc_cnt;
      push_line(10'd41, 1'b1, 1'b1, rand_payload());
      n = 0;
      while (acc_cnt < base_acc + 11 && n < 500) begin
         @(negedge clk);
         #2;
         n++;
      end
      check_eq("t6_reach_beat10", 32'(acc_cnt - base_acc), 32'd11);
      rst_async = 1'b1;
      #1;
      check_eq("t6_reset_outputs",
               32'({ff_rdreq, source_valid, source_data, source_sop, source_eop, len_err}), 32'd0);
      exp_pushed = exp_pushed - exp_q.size();
      exp_q.delete();
      exp_len_err = 1'b0;
      repeat (3) @(negedge clk);
      rst_async = 1'b0;
      @(negedge clk);
      base_acc = acc_cnt;
      push_line(10'd7, 1'b1, 1'b1, rand_payload());
      wait_drain();
      check_eq("t6_beats_after", 32'(acc_cnt - base_acc), 32'd7);
      check_eq("t6_len_err", 32'(len_err), 32'(exp_len_err));

      // Test 7: random lines with random ready
      ready_mode = 2;
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      len = 10'd0;
         else if (r == 1) len = 10'($urandom_range(42, 1023));
         else             len = 10'($urandom_range(1, 41));
         push_line(len, 1'($urandom), 1'($urandom), rand_payload());
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_drain();
      check_eq("t7_len_err", 32'(len_err), 32'(exp_len_err));
      check_eq("total_beats", 32'(acc_cnt), 32'(exp_pushed));
      check_eq("fifo_consumed", 32'(rd_ptr), 32'(wr_ptr));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #2000000;
      check_eq("global_timeout", 32'd1, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
